control_sequencer: RTL and testbench

//  Moore control unit that drives the DataPath control lines for one instruction at a time.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/instr_decode.sv | 34 +++
 rtl/control_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, state codes,
// IR field positions and the decoded-instruction record.
package cpu_pkg;

    // Opcodes carried in IR[31:27]
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h0A;
    localparam logic [4:0] OP_OR   = 5'h0B;
    localparam logic [4:0] OP_MUL  = 5'h0E;
    localparam logic [4:0] OP_DIV  = 5'h0F;
    localparam logic [4:0] OP_NEG  = 5'h10;
    localparam logic [4:0] OP_NOT  = 5'h11;
    localparam logic [4:0] OP_NOP  = 5'h18;
    localparam logic [4:0] OP_SHR  = 5'h19;
    localparam logic [4:0] OP_SHL  = 5'h1A;
    localparam logic [4:0] OP_HALT = 5'h1B;

    // Sequencer state encodings (visible on the debug state port)
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_DEC  = 4'd5;
    localparam logic [3:0] ST_T4   = 4'd6;
    localparam logic [3:0] ST_T5   = 4'd7;
    localparam logic [3:0] ST_T6   = 4'd8;
    localparam logic [3:0] ST_HLT  = 4'd9;
    localparam logic [3:0] ST_FLT  = 4'd10;

    // IR field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    // Decoded view of the instruction register
    typedef struct packed {
        logic [4:0] opcode;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
        logic       is_alu;
        logic       is_hilo;
        logic       is_unary;
        logic       is_nop;
        logic       is_halt;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: splits IR into register fields
// and classifies the opcode into the groups the sequencer branches on.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output decode_t     dec
);

    // Low IR bits carry immediates/unused fields the sequencer never looks at
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[RC_LSB-1:0];

    // Field extraction and opcode classification
    always_comb begin
        dec          = '0;
        dec.opcode   = ir[OPC_MSB:OPC_LSB];
        dec.ra       = ir[RA_MSB:RA_LSB];
        dec.rb       = ir[RB_MSB:RB_LSB];
        dec.rc       = ir[RC_MSB:RC_LSB];
        case (ir[OPC_MSB:OPC_LSB])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: dec.is_alu = 1'b1;
            OP_NEG, OP_NOT: begin
                dec.is_alu   = 1'b1;
                dec.is_unary = 1'b1;
            end
            OP_MUL, OP_DIV: dec.is_hilo  = 1'b1;
            OP_NOP:         dec.is_nop   = 1'b1;
            OP_HALT:        dec.is_halt  = 1'b1;
            default:        dec.illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit stepping one instruction through fetch (T0-T2),
// operand read (T3), decode, ALU execute with start/finished handshake (T4)
// and writeback (T5/T6). Outputs depend only on the state register, the
// T4 cycle counter and IR, so run/finished never reach an output directly.
// CNT_W must be wide enough that 2**CNT_W > ALU_TIMEOUT.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int ALU_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        finished,
    output logic        RFout,
    output logic        PCout,
    output logic        IRout,
    output logic        RYout,
    output logic        RZLOout,
    output logic        RZHIout,
    output logic        MARout,
    output logic        RHIout,
    output logic        RLOout,
    output logic        RFin,
    output logic        PCin,
    output logic        IRin,
    output logic        RYin,
    output logic        RZin,
    output logic        MARin,
    output logic        RHIin,
    output logic        RLOin,
    output logic [3:0]  RFSelect,
    output logic [5:0]  opSelect,
    output logic        start,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IncPC,
    output logic        halted,
    output logic        fault,
    output logic [3:0]  state
);

    decode_t          dec;
    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic             first_t4;
    logic             timeout_hit;

    instr_decode u_decode (
        .ir  (IR),
        .dec (dec)
    );

    // cnt is zero in the first T4 cycle, so it doubles as the stale-finished mask
    assign first_t4    = (cnt == '0);
    assign timeout_hit = (cnt == CNT_W'(ALU_TIMEOUT - 1));

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = ST_DEC;
            ST_DEC: begin
                if (dec.is_halt)      state_d = ST_HLT;
                else if (dec.is_nop)  state_d = ST_T5;
                else if (dec.illegal) state_d = ST_FLT;
                else                  state_d = ST_T4;
            end
            ST_T4: begin
                if (!first_t4 && finished) state_d = ST_T5;
                else if (timeout_hit)      state_d = ST_FLT;
            end
            ST_T5: begin
                if (dec.is_hilo) state_d = ST_T6;
                else             state_d = run ? ST_T0 : ST_IDLE;
            end
            ST_T6:   state_d = run ? ST_T0 : ST_IDLE;
            ST_HLT:  state_d = ST_HLT;
            ST_FLT:  state_d = ST_FLT;
            default: state_d = ST_FLT;
        endcase
    end

    // State register
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // T4 cycle counter, held at zero outside T4 so every T4 entry starts fresh
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear)              cnt <= '0;
        else if (state_q != ST_T4) cnt <= '0;
        else                     cnt <= cnt + 1'b1;
    end

    // Control line decode from state and IR
    always_comb begin
        RFout    = 1'b0;
        PCout    = 1'b0;
        IRout    = 1'b0;
        RYout    = 1'b0;
        RZLOout  = 1'b0;
        RZHIout  = 1'b0;
        MARout   = 1'b0;
        RHIout   = 1'b0;
        RLOout   = 1'b0;
        RFin     = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        RYin     = 1'b0;
        RZin     = 1'b0;
        MARin    = 1'b0;
        RHIin    = 1'b0;
        RLOin    = 1'b0;
        RFSelect = 4'd0;
        opSelect = 6'd0;
        start    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IncPC    = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RZin  = 1'b1;
            end
            ST_T1: begin
                RZLOout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                RFSelect = dec.rb;
                RFout    = 1'b1;
                RYin     = 1'b1;
            end
            ST_T4: begin
                RFSelect = dec.is_unary ? dec.rb : dec.rc;
                RFout    = 1'b1;
                opSelect = {1'b0, dec.opcode};
                RZin     = 1'b1;
                start    = first_t4;
            end
            ST_T5: begin
                if (dec.is_alu) begin
                    RFSelect = dec.ra;
                    RZLOout  = 1'b1;
                    RFin     = 1'b1;
                end else if (dec.is_hilo) begin
                    RZLOout = 1'b1;
                    RLOin   = 1'b1;
                end
            end
            ST_T6: begin
                RZHIout = 1'b1;
                RHIin   = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted = (state_q == ST_HLT);
    assign fault  = (state_q == ST_FLT);
    assign state  = state_q;

    // Only one driver may own the shared bus in any cycle
    a_one_bus_driver: assert property (@(posedge Clock) disable iff (!clear)
        $onehot0({RFout, PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout}));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a small behavioural register
// file / ALU driven by the control lines (R2=8, R3=2 after each reset).
module tb_control_sequencer;
    import cpu_pkg::*;

    logic        Clock;
    logic        clear;
    logic        run;
    logic [31:0] IR;
    logic        finished;
    logic RFout, PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout;
    logic RFin, PCin, IRin, RYin, RZin, MARin, RHIin, RLOin;
    logic [3:0] RFSelect;
    logic [5:0] opSelect;
    logic start, Read, MDRin, MDRout, IncPC, halted, fault;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.ALU_TIMEOUT(64), .CNT_W(7)) dut (
        .Clock(Clock), .clear(clear), .run(run), .IR(IR), .finished(finished),
        .RFout(RFout), .PCout(PCout), .IRout(IRout), .RYout(RYout),
        .RZLOout(RZLOout), .RZHIout(RZHIout), .MARout(MARout), .RHIout(RHIout),
        .RLOout(RLOout), .RFin(RFin), .PCin(PCin), .IRin(IRin), .RYin(RYin),
        .RZin(RZin), .MARin(MARin), .RHIin(RHIin), .RLOin(RLOin),
        .RFSelect(RFSelect), .opSelect(opSelect), .start(start), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IncPC(IncPC), .halted(halted),
        .fault(fault), .state(state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [31:0] ctl_all;
    assign ctl_all = {RFout, PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout,
                      RLOout, RFin, PCin, IRin, RYin, RZin, MARin, RHIin, RLOin,
                      start, Read, MDRin, MDRout, IncPC, RFSelect, opSelect};

    // Behavioural datapath reacting to the control lines
    logic [31:0] regs [16];
    logic [31:0] y_reg, lo_reg, hi_reg;
    logic [63:0] z_reg;

    function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            OP_ADD:  return {32'd0, a + b};
            OP_SUB:  return {32'd0, a - b};
            OP_AND:  return {32'd0, a & b};
            OP_OR:   return {32'd0, a | b};
            OP_SHR:  return {32'd0, a >> b[4:0]};
            OP_SHL:  return {32'd0, a << b[4:0]};
            OP_MUL:  return {32'd0, a} * {32'd0, b};
            OP_DIV:  return {a % b, a / b};
            OP_NEG:  return {32'd0, -b};
            OP_NOT:  return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
            regs[2] <= 32'd8;
            regs[3] <= 32'd2;
            y_reg  <= 32'd0;
            z_reg  <= 64'd0;
            lo_reg <= 32'd0;
            hi_reg <= 32'd0;
        end else begin
            if (RFout && RYin)   y_reg <= regs[RFSelect];
            if (RFout && RZin)   z_reg <= alu(opSelect[4:0], y_reg, regs[RFSelect]);
            if (RZLOout && RFin) regs[RFSelect] <= z_reg[31:0];
            if (RZLOout && RLOin) lo_reg <= z_reg[31:0];
            if (RZHIout && RHIin) hi_reg <= z_reg[63:32];
        end
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        run = 1'b0;
        finished = 1'b0;
        tick();
        tick();
        clear = 1'b1;
    endtask

    // Results of the last run_instr call
    int         r_pre, r_t4, r_starts, r_rfin, r_held_bad, r_t6;
    logic [3:0] r_end;
    logic [5:0] r_op;

    // Launch one instruction (run dropped after T0) and record what happened.
    // fin_delay < 0 means finished is never raised.
    task automatic run_instr(input logic [31:0] ir_v, input int fin_delay);
        r_pre = 0; r_t4 = 0; r_starts = 0; r_rfin = 0; r_held_bad = 0; r_t6 = 0;
        r_op = 6'd0;
        IR = ir_v;
        run = 1'b1;
        finished = 1'b0;
        tick();
        run = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (state == ST_T5 || state == ST_HLT || state == ST_FLT || state == ST_IDLE) break;
            r_pre++;
            if (start) r_starts++;
            if (state == ST_T4) begin
                r_t4++;
                r_op = opSelect;
                if (!(RZin && RFout)) r_held_bad++;
            end
            finished = (state == ST_T4) && (fin_delay >= 0) && (r_t4 >= fin_delay + 1);
            tick();
        end
        finished = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (state != ST_T5 && state != ST_T6) break;
            if (RFin) r_rfin++;
            if (start) r_starts++;
            if (state == ST_T6) r_t6++;
            tick();
        end
        r_end = state;
    endtask

    task automatic test_reset();
        clear = 1'b0; run = 1'b1; finished = 1'b1; IR = mk_ir(OP_ADD, 4'd1, 4'd2, 4'd3);
        #3;
        checks++;
        if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0h want %0h", state, ST_IDLE); end
        checks++;
        if (ctl_all !== 32'd0) begin errors++; $display("FAIL reset_ctl got %0h want 0", ctl_all); end
        checks++;
        if (halted !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL reset_flags got %b%b want 00", halted, fault);
        end
        tick();
        run = 1'b0; finished = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        checks++;
        if (state !== ST_IDLE) begin errors++; $display("FAIL idle_hold got %0h want %0h", state, ST_IDLE); end
    endtask

    task automatic test_shr();
        do_reset();
        run_instr(32'hC8918000, 1);
        checks++;
        if (r_pre !== 7) begin errors++; $display("FAIL shr_cycles got %0d want 7", r_pre); end
        checks++;
        if (r_starts !== 1) begin errors++; $display("FAIL shr_start got %0d want 1", r_starts); end
        checks++;
        if (r_op !== 6'h19) begin errors++; $display("FAIL shr_opsel got %0h want 19", r_op); end
        checks++;
        if (regs[1] !== 32'h2) begin errors++; $display("FAIL shr_r1 got %0h want 2", regs[1]); end
        checks++;
        if (r_end !== ST_IDLE || halted !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL shr_end got %0h/%b%b want %0h/00", r_end, halted, fault, ST_IDLE);
        end
    endtask

    task automatic test_alu_wait();
        do_reset();
        run_instr(mk_ir(OP_ADD, 4'd4, 4'd2, 4'd3), 10);
        checks++;
        if (r_t4 !== 11) begin errors++; $display("FAIL wait_t4 got %0d want 11", r_t4); end
        checks++;
        if (r_held_bad !== 0) begin errors++; $display("FAIL wait_held got %0d want 0", r_held_bad); end
        checks++;
        if (r_starts !== 1) begin errors++; $display("FAIL wait_start got %0d want 1", r_starts); end
        checks++;
        if (regs[4] !== 32'd10) begin errors++; $display("FAIL wait_r4 got %0h want a", regs[4]); end
    endtask

    task automatic test_stale_finished();
        do_reset();
        run_instr(mk_ir(OP_SUB, 4'd5, 4'd2, 4'd3), 0);
        checks++;
        if (r_t4 !== 2) begin errors++; $display("FAIL stale_t4 got %0d want 2", r_t4); end
        checks++;
        if (regs[5] !== 32'd6) begin errors++; $display("FAIL stale_r5 got %0h want 6", regs[5]); end
    endtask

    task automatic test_unary();
        do_reset();
        run_instr(mk_ir(OP_NOT, 4'd6, 4'd2, 4'd3), 1);
        checks++;
        if (regs[6] !== 32'hFFFF_FFF7) begin
            errors++; $display("FAIL not_r6 got %0h want fffffff7", regs[6]);
        end
    endtask

    task automatic test_mul();
        do_reset();
        run_instr(mk_ir(OP_MUL, 4'd7, 4'd2, 4'd3), 1);
        checks++;
        if (lo_reg !== 32'd16) begin errors++; $display("FAIL mul_lo got %0h want 10", lo_reg); end
        checks++;
        if (hi_reg !== 32'd0) begin errors++; $display("FAIL mul_hi got %0h want 0", hi_reg); end
        checks++;
        if (r_rfin !== 0) begin errors++; $display("FAIL mul_rfin got %0d want 0", r_rfin); end
        checks++;
        if (r_t6 !== 1 || r_end !== ST_IDLE) begin
            errors++; $display("FAIL mul_t6 got %0d/%0h want 1/%0h", r_t6, r_end, ST_IDLE);
        end
    endtask

    task automatic test_nop();
        do_reset();
        run_instr(mk_ir(OP_NOP, 4'd1, 4'd2, 4'd3), 1);
        checks++;
        if (r_pre !== 5 || r_t4 !== 0 || r_starts !== 0) begin
            errors++; $display("FAIL nop_flow got %0d/%0d/%0d want 5/0/0", r_pre, r_t4, r_starts);
        end
        checks++;
        if (r_rfin !== 0 || r_end !== ST_IDLE || regs[1] !== 32'd0) begin
            errors++; $display("FAIL nop_wb got %0d/%0h/%0h want 0/%0h/0", r_rfin, r_end, regs[1], ST_IDLE);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_instr(mk_ir(OP_ADD, 4'd4, 4'd2, 4'd3), -1);
        checks++;
        if (r_t4 !== 64) begin errors++; $display("FAIL tmo_t4 got %0d want 64", r_t4); end
        checks++;
        if (fault !== 1'b1 || r_end !== ST_FLT) begin
            errors++; $display("FAIL tmo_fault got %b/%0h want 1/%0h", fault, r_end, ST_FLT);
        end
        run = 1'b1;
        finished = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (state !== ST_FLT || ctl_all !== 32'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL tmo_frozen got %0h/%0h/%b want %0h/0/0", state, ctl_all, halted, ST_FLT);
        end
        run = 1'b0;
        finished = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        run_instr(mk_ir(5'h1F, 4'd1, 4'd2, 4'd3), 1);
        checks++;
        if (fault !== 1'b1 || r_end !== ST_FLT || r_pre !== 5) begin
            errors++; $display("FAIL ill_fault got %b/%0h/%0d want 1/%0h/5", fault, r_end, r_pre, ST_FLT);
        end
        checks++;
        if (r_starts !== 0) begin errors++; $display("FAIL ill_start got %0d want 0", r_starts); end
    endtask

    task automatic test_halt();
        do_reset();
        run_instr(mk_ir(OP_HALT, 4'd0, 4'd0, 4'd0), 1);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b0 || r_end !== ST_HLT) begin
            errors++; $display("FAIL halt_flag got %b%b/%0h want 10/%0h", halted, fault, r_end, ST_HLT);
        end
        run = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (state !== ST_HLT || ctl_all !== 32'd0) begin
            errors++; $display("FAIL halt_absorb got %0h/%0h want %0h/0", state, ctl_all, ST_HLT);
        end
        run = 1'b0;
    endtask

    task automatic test_back_to_back();
        int seen_t5;
        seen_t5 = 0;
        do_reset();
        IR = mk_ir(OP_OR, 4'd8, 4'd2, 4'd3);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            finished = (state == ST_T4) && !start;
            if (state == ST_T5) begin
                seen_t5 = 1;
                break;
            end
        end
        finished = 1'b0;
        tick();
        checks++;
        if (seen_t5 !== 1 || state !== ST_T0) begin
            errors++; $display("FAIL b2b_next got %0d/%0h want 1/%0h", seen_t5, state, ST_T0);
        end
        checks++;
        if (regs[8] !== 32'd10) begin errors++; $display("FAIL b2b_r8 got %0h want a", regs[8]); end
        run = 1'b0;
    endtask

    task automatic test_clear_mid();
        int seen_t4;
        seen_t4 = 0;
        do_reset();
        IR = mk_ir(OP_ADD, 4'd4, 4'd2, 4'd3);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state == ST_T4) begin
                seen_t4 = 1;
                break;
            end
        end
        tick();
        #2;
        clear = 1'b0;
        #1;
        checks++;
        if (seen_t4 !== 1 || state !== ST_IDLE || ctl_all !== 32'd0) begin
            errors++; $display("FAIL clr_async got %0d/%0h/%0h want 1/%0h/0", seen_t4, state, ctl_all, ST_IDLE);
        end
        tick();
        clear = 1'b1;
        tick();
        checks++;
        if (state !== ST_T0) begin errors++; $display("FAIL clr_restart got %0h want %0h", state, ST_T0); end
        run = 1'b0;
    endtask

    initial begin
        clear = 1'b0;
        run = 1'b0;
        IR = 32'd0;
        finished = 1'b0;
        test_reset();
        test_shr();
        test_alu_wait();
        test_stale_finished();
        test_unary();
        test_mul();
        test_nop();
        test_timeout();
        test_illegal();
        test_halt();
        test_back_to_back();
        test_clear_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
